// File: rtl/clock_period_meter_if.sv
// Measurement bus of clock_period_meter: input under test, start request, and held results.
interface clock_period_meter_if #(
  parameter int CNT_W = 8
);
  logic             sig_in;
  logic             start;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] high_cycles;
  logic [CNT_W-1:0] low_cycles;
  logic [CNT_W:0]   period;
  logic             overflow;

  modport master (
    output sig_in, start,
    input  busy, done, high_cycles, low_cycles, period, overflow
  );

  modport slave (
    input  sig_in, start,
    output busy, done, high_cycles, low_cycles, period, overflow
  );
endinterface

// File: rtl/clock_period_meter.sv
// Measures high time, low time and period of a divided clock, in clk_in cycles.
// One measurement per start pulse; results and overflow hold until the next done.
module clock_period_meter #(
  parameter int CNT_W = 8
) (
  input  logic                 clk_in,
  input  logic                 rst,
  clock_period_meter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic             s1_q, s1_d, s2_q, s2_d, sd_q, sd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [CNT_W:0]   period_q, period_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             rise, fall, edge_hit;

  assign rise = s2_q & ~sd_q;
  assign fall = ~s2_q & sd_q;

  always_comb begin
    state_d  = state_q;
    s1_d     = bus.sig_in;
    s2_d     = s1_q;
    sd_d     = s2_q;
    cnt_d    = cnt_q;
    high_d   = high_q;
    low_d    = low_q;
    period_d = period_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    edge_hit = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ARM;
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
        end
      end
      ARM: begin
        edge_hit = rise;
        if (rise) begin
          state_d = HIGH;
          cnt_d   = CNT_W'(1);
        end
      end
      HIGH: begin
        edge_hit = fall;
        if (fall) begin
          high_d  = cnt_q;
          cnt_d   = CNT_W'(1);
          state_d = LOW;
        end
      end
      LOW: begin
        edge_hit = rise;
        if (rise) begin
          low_d    = cnt_q;
          period_d = {1'b0, high_q} + {1'b0, cnt_q};
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
    endcase

    // While waiting for an edge: count, or give up at saturation and
    // report all-ones, discarding anything captured earlier this run.
    if (state_q != IDLE && !edge_hit) begin
      if (cnt_q == CNT_MAX) begin
        high_d   = CNT_MAX;
        low_d    = CNT_MAX;
        period_d = {1'b0, CNT_MAX} + {1'b0, CNT_MAX};
        ovf_d    = 1'b1;
        done_d   = 1'b1;
        state_d  = IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q  <= IDLE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      sd_q     <= 1'b0;
      cnt_q    <= '0;
      high_q   <= '0;
      low_q    <= '0;
      period_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      sd_q     <= sd_d;
      cnt_q    <= cnt_d;
      high_q   <= high_d;
      low_q    <= low_d;
      period_q <= period_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.high_cycles = high_q;
  assign bus.low_cycles  = low_q;
  assign bus.period      = period_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: doc/clock_period_meter.md
# clock_period_meter

Measures the high time, low time and period of a single divided clock produced by the lab2 clock generator stage (e.g. the /2, /4, /8, /16, /28 or /5 outputs). All counts are in `clk_in` cycles. Each `start` pulse triggers one measurement. Results are held for inspection by the board display/LED logic until the next measurement completes.

## Interface
- `CNT_W`, default 8: width of the high/low counters. The saturation value is 2^CNT_W−1.
- `clk_in`, input, 1: system clock. All logic is on its rising edge.
- `rst`, input, 1: **synchronous, active-high** reset.
- `sig_in`, input, 1: divided clock under measurement. It passes through a 2-flop synchronizer before use.
- `start`, input, 1: single-cycle request to begin a measurement.
- `busy`, output, 1: high while a measurement is in progress.
- `done`, output, 1: one-cycle pulse when the results update.
- `high_cycles`, output, CNT_W: measured high time.
- `low_cycles`, output, CNT_W: measured low time.
- `period`, output, CNT_W+1: `high_cycles + low_cycles`. It is zero-extended, so there is no wrap.
- `overflow`, output, 1: the last measurement hit saturation.

## Operation
- Synchronizer and edge detect:
  - `s1 <= sig_in`, `s2 <= s1`, `sd <= s2`.
  - `rise = s2 & ~sd`, `fall = ~s2 & sd`.
  - The synchronizer and `sd` are cleared by `rst`.
- State machine: IDLE, ARM, HIGH, LOW. Internal counter `cnt` is CNT_W bits wide.
  - **IDLE**:
    - `start` → ARM, `cnt <= 1`, `overflow <= 0`.
    - Edges seen while in IDLE are ignored.
  - **ARM**:
    - `rise` → HIGH, `cnt <= 1`.
    - Otherwise `cnt <= cnt+1`.
  - **HIGH**:
    - `fall` → `high_cycles <= cnt`, `cnt <= 1`, go to LOW.
    - Otherwise `cnt <= cnt+1`.
  - **LOW**:
    - `rise` → `low_cycles <= cnt`, `period <= high_cycles_new + cnt`, `done <= 1`, go to IDLE.
    - Otherwise `cnt <= cnt+1`.
- Saturation:
  - Applies in ARM, HIGH or LOW, when `cnt == 2^CNT_W−1` and the awaited edge is absent.
  - Response: `high_cycles` and `low_cycles` are both set to all-ones, `period` to their sum, `overflow <= 1`, `done <= 1`, then go to IDLE.
  - Already-captured results from the current measurement are overwritten.
- `busy` is 1 exactly when the state is ARM, HIGH or LOW.
- `start` while busy is ignored and does not restart the measurement.
- Results and `overflow` hold their values from `done` until the next `done`.
- Reset values:
  - State is IDLE.
  - `busy`, `done`, `overflow`, `high_cycles`, `low_cycles` and `period` are all 0.
  - `cnt` is 0.
- `rst` asserted mid-measurement aborts it immediately: all of the reset values above apply and no `done` is issued.
- `rst` and `start` in the same cycle: `rst` wins.

## Timing
- A `sig_in` transition at posedge N becomes `s2` at N+2 and is detected during the cycle after N+2.
- The synchronizer latency is identical for both edges, so measured counts are exact for signals launched on `clk_in` rising edges.
- The minimum measurable high or low time is 1 cycle (the /2 output).
- `done` and the updated results appear together, one cycle after the clock edge at which the terminating `rise` is sampled in LOW.
- Worst-case measurement latency after `start` is 3·(2^CNT_W−1)+1 cycles. This is the overflow path with the edge arriving late in each state.
- `sig_in` edges produced on `clk_in` falling edges (the /5 output) are quantized to whole cycles. High and low are each 2 or 3, and `period` is 5.

## Test plan
- **/2 output**: release `rst`, run 4 cycles, pulse `start` → `done` with `high_cycles=1`, `low_cycles=1`, `period=2`, `overflow=0`.
- **/28 output**: pulse `start` → `high_cycles=14`, `low_cycles=14`, `period=28`. A second `start` gives identical results. /16 gives 8/8/16.
- **/5 output**: pulse `start` → `period=5`, `{high_cycles,low_cycles}` equal to {2,3} or {3,2}, `overflow=0`.
- **No edge**: hold `sig_in=0`, `CNT_W=8`, pulse `start` → after 255 cycles in ARM, `done` with `high_cycles=255`, `low_cycles=255`, `period=510`, `overflow=1`, `busy=0`.
- **Reset mid-measurement**: with the /16 input, pulse `start`, assert `rst` while in HIGH → next cycle all outputs are 0 and no `done`. A new `start` then yields 8/8/16.
- **Start while busy**: with the /28 input, pulse `start`, pulse `start` again 5 cycles later → exactly one `done`, with timing and results matching a single `start` (14/14/28).
